// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle shared by the fetch/load-store requesters, the arbiter and the unified memory.
// slave: arbiter side; master: requester/memory/testbench side.
interface unified_mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_size;
  logic        d_gnt;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        halt;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_size;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        halted;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, halt, mem_rdata,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_size, stall, halted
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, halt, mem_rdata,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_size, stall, halted
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Data-priority arbiter for the single-ported unified I/D memory, with stall and ebreak drain/freeze.
// Optional `define ARB_FAIR_EN adds a fetch starvation counter that forces a fetch grant after STARVE_MAX losses.
module unified_mem_arbiter #(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  unified_mem_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = 3;

  if (MEM_LAT < 1 || MEM_LAT > 7 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_param_check
    $error("unified_mem_arbiter: MEM_LAT or STARVE_MAX out of range");
  end

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, HALTED} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             halt_pend;
  logic             grant_i;
  logic             grant_d;
  logic             busy;
  logic             last_beat;
  logic             fetch_first;

  assign busy      = (state == BUSY_I) || (state == BUSY_D);
  assign last_beat = busy && (cnt == CNT_W'(1));

`ifdef ARB_FAIR_EN
  localparam int unsigned STV_W = 4;
  logic [STV_W-1:0] starve;

  assign fetch_first = bus.if_req && bus.d_req && (starve >= STV_W'(STARVE_MAX));

  // Fetch losses to data; any fetch grant restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve <= '0;
    end else if (grant_i) begin
      starve <= '0;
    end else if (grant_d && bus.if_req) begin
      starve <= starve + STV_W'(1);
    end
  end
`else
  assign fetch_first = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and grant decision; halt (live or latched while busy) beats any request
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.halt || halt_pend) begin
          state_nxt = HALTED;
        end else if (bus.d_req && !fetch_first) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
        end else if (bus.if_req) begin
          grant_i   = 1'b1;
          state_nxt = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (last_beat) begin
          state_nxt = IDLE;
        end
      end
      HALTED:  state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  // Grants, stall and halted status
  always_comb begin
    bus.if_gnt = grant_i;
    bus.d_gnt  = grant_d;
    bus.halted = (state == HALTED);
    bus.stall  = 1'b0;
    case (state)
      BUSY_I, BUSY_D: bus.stall = 1'b1;
      IDLE:           bus.stall = (bus.if_req && !grant_i) || (bus.d_req && !grant_d);
      default:        bus.stall = 1'b0;
    endcase
  end

  // Memory command registers, latency counter and read-data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_size  <= '0;
      bus.if_valid  <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_valid   <= 1'b0;
      bus.d_rdata   <= '0;
      cnt           <= '0;
      halt_pend     <= 1'b0;
    end else begin
      bus.if_valid <= 1'b0;
      bus.d_valid  <= 1'b0;
      if (busy && bus.halt) begin
        halt_pend <= 1'b1;
      end
      if (grant_d) begin
        bus.mem_en    <= 1'b1;
        bus.mem_we    <= bus.d_we;
        bus.mem_addr  <= bus.d_addr;
        bus.mem_wdata <= bus.d_wdata;
        bus.mem_size  <= bus.d_size;
        cnt           <= CNT_W'(MEM_LAT);
      end else if (grant_i) begin
        bus.mem_en   <= 1'b1;
        bus.mem_we   <= 1'b0;
        bus.mem_addr <= bus.if_addr;
        bus.mem_size <= 2'b10;
        cnt          <= CNT_W'(MEM_LAT);
      end else if (last_beat) begin
        bus.mem_en <= 1'b0;
        cnt        <= '0;
        if (state == BUSY_I) begin
          bus.if_valid <= 1'b1;
          bus.if_rdata <= bus.mem_rdata;
        end else begin
          bus.d_valid <= 1'b1;
          if (!bus.mem_we) begin
            bus.d_rdata <= bus.mem_rdata;
          end
        end
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end
endmodule
